// File: rtl/writeback_stage.sv
// Writeback pipeline stage: registers the M-stage result, then decodes the
// registered instruction to produce the register-file write port and retire count.
module writeback_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_M,
  input  logic [31:0] Instr_M,
  input  logic [31:0] PC_M,
  input  logic [31:0] ALUOut_M,
  input  logic [31:0] ReadData_M,
  output logic [4:0]  A3_W,
  output logic [31:0] WD_W,
  output logic        RegWrite_W,
  output logic [31:0] Addr_prt,
  output logic [31:0] retire_cnt
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  typedef enum logic [2:0] {
    WD_ALU, WD_LINK, WD_LW, WD_LB, WD_LBU, WD_LH, WD_LHU
  } wd_sel_e;

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] alu_out_q;
  logic [31:0] read_data_q;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // active-low reset, so outputs fall to reset values without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      instr_q      <= '0;
      pc_q         <= RESET_PC;
      alu_out_q    <= '0;
      read_data_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      valid_q      <= valid_M;
      instr_q      <= Instr_M;
      pc_q         <= PC_M;
      alu_out_q    <= ALUOut_M;
      read_data_q  <= ReadData_M;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Counts the instruction leaving W on this edge; wraps naturally at 2^32.
  assign retire_cnt_d = retire_cnt_q + {31'b0, valid_q};

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs_unused_rt;
  logic [4:0] rt;
  logic [4:0] rd;

  assign opcode = instr_q[31:26];
  assign funct  = instr_q[5:0];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];

  logic       writes;
  logic [4:0] a3_raw;
  wd_sel_e    wd_sel;

  // NOTE: every signal assigned in this block gets a default first, which
  // keeps unlisted opcodes non-writing and prevents latch inference.
  always_comb begin
    writes = 1'b0;
    a3_raw = 5'd0;
    wd_sel = WD_ALU;
    unique case (opcode)
      OP_SPECIAL: begin
        if (funct == FN_ADDU || funct == FN_SUBU) begin
          writes = 1'b1;
          a3_raw = rd;
        end
      end
      OP_ORI, OP_LUI: begin
        writes = 1'b1;
        a3_raw = rt;
      end
      OP_LW:  begin writes = 1'b1; a3_raw = rt; wd_sel = WD_LW;  end
      OP_LB:  begin writes = 1'b1; a3_raw = rt; wd_sel = WD_LB;  end
      OP_LBU: begin writes = 1'b1; a3_raw = rt; wd_sel = WD_LBU; end
      OP_LH:  begin writes = 1'b1; a3_raw = rt; wd_sel = WD_LH;  end
      OP_LHU: begin writes = 1'b1; a3_raw = rt; wd_sel = WD_LHU; end
      OP_JAL: begin
        writes = 1'b1;
        a3_raw = 5'd31;
        wd_sel = WD_LINK;
      end
      default: ;
    endcase
  end

  logic [7:0]  mem_byte;
  logic [15:0] mem_half;

  always_comb begin
    mem_byte = 8'h00;
    unique case (alu_out_q[1:0])
      2'd0: mem_byte = read_data_q[7:0];
      2'd1: mem_byte = read_data_q[15:8];
      2'd2: mem_byte = read_data_q[23:16];
      2'd3: mem_byte = read_data_q[31:24];
      default: ;
    endcase
  end

  // Halfword lane is chosen by address bit 1 only; bit 0 is ignored.
  assign mem_half = alu_out_q[1] ? read_data_q[31:16] : read_data_q[15:0];

  logic [31:0] wd_raw;

  always_comb begin
    wd_raw = alu_out_q;
    unique case (wd_sel)
      WD_LINK: wd_raw = pc_q + 32'd8;
      WD_LW:   wd_raw = read_data_q;
      WD_LB:   wd_raw = {{24{mem_byte[7]}}, mem_byte};
      WD_LBU:  wd_raw = {24'h0, mem_byte};
      WD_LH:   wd_raw = {{16{mem_half[15]}}, mem_half};
      WD_LHU:  wd_raw = {16'h0, mem_half};
      default: wd_raw = alu_out_q;
    endcase
  end

  logic reg_write;

  assign reg_write  = valid_q && writes && (a3_raw != 5'd0);
  assign RegWrite_W = reg_write;
  assign A3_W       = reg_write ? a3_raw : 5'd0;
  assign WD_W       = reg_write ? wd_raw : 32'd0;
  assign Addr_prt   = pc_q;
  assign retire_cnt = retire_cnt_q;

  // rs and shamt fields are never consulted by this stage.
  logic unused_fields;
  assign rs_unused_rt  = instr_q[25:21];
  assign unused_fields = ^{rs_unused_rt, instr_q[10:6]};

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: each issued M-stage instruction pushes
// its expected W outputs, which are popped and compared one cycle later.
module tb_writeback_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_M;
  logic [31:0] Instr_M;
  logic [31:0] PC_M;
  logic [31:0] ALUOut_M;
  logic [31:0] ReadData_M;
  logic [4:0]  A3_W;
  logic [31:0] WD_W;
  logic        RegWrite_W;
  logic [31:0] Addr_prt;
  logic [31:0] retire_cnt;

  writeback_stage #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_M    (valid_M),
    .Instr_M    (Instr_M),
    .PC_M       (PC_M),
    .ALUOut_M   (ALUOut_M),
    .ReadData_M (ReadData_M),
    .A3_W       (A3_W),
    .WD_W       (WD_W),
    .RegWrite_W (RegWrite_W),
    .Addr_prt   (Addr_prt),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic        we;
    logic [31:0] addr;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_cnt;
  logic        prev_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model for randomised vectors, written from the instruction table.
  task automatic model(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       output logic [4:0] a3, output logic [31:0] wd, output logic we);
    logic [5:0]  op;
    logic [31:0] shifted;
    op      = instr[31:26];
    shifted = rdata >> (8 * alu[1:0]);
    a3 = 5'd0;
    wd = alu;
    if (op == 6'h00 && (instr[5:0] == 6'h21 || instr[5:0] == 6'h23)) a3 = instr[15:11];
    else if (op == 6'h0D || op == 6'h0F) a3 = instr[20:16];
    else if (op == 6'h23) begin a3 = instr[20:16]; wd = rdata; end
    else if (op == 6'h20) begin a3 = instr[20:16]; wd = {{24{shifted[7]}}, shifted[7:0]}; end
    else if (op == 6'h24) begin a3 = instr[20:16]; wd = {24'h0, shifted[7:0]}; end
    else if (op == 6'h21 || op == 6'h25) begin
      a3 = instr[20:16];
      shifted = alu[1] ? {16'h0, rdata[31:16]} : {16'h0, rdata[15:0]};
      wd = (op == 6'h21) ? {{16{shifted[15]}}, shifted[15:0]} : shifted;
    end
    else if (op == 6'h03) begin a3 = 5'd31; wd = pc + 32'd8; end
    we = v && (a3 != 5'd0);
    if (!we) begin a3 = 5'd0; wd = 32'd0; end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic issue(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [4:0] a3, input logic [31:0] wd, input logic we,
                       input string tag);
    exp_t e;
    valid_M    = v;
    Instr_M    = instr;
    PC_M       = pc;
    ALUOut_M   = alu;
    ReadData_M = rdata;
    exp_cnt    = exp_cnt + {31'b0, prev_valid};
    prev_valid = v;
    e.a3 = a3; e.wd = wd; e.we = we; e.addr = pc; e.cnt = exp_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check({tag, ".A3"},   {27'b0, A3_W},       {27'b0, e.a3});
    check({tag, ".WD"},   WD_W,                e.wd);
    check({tag, ".WE"},   {31'b0, RegWrite_W}, {31'b0, e.we});
    check({tag, ".ADDR"}, Addr_prt,            e.addr);
    check({tag, ".CNT"},  retire_cnt,          e.cnt);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".A3"},   {27'b0, A3_W},       32'd0);
    check({tag, ".WD"},   WD_W,                32'd0);
    check({tag, ".WE"},   {31'b0, RegWrite_W}, 32'd0);
    check({tag, ".ADDR"}, Addr_prt,            RESET_PC);
    check({tag, ".CNT"},  retire_cnt,          32'd0);
  endtask

  initial begin
    logic [5:0]  ops [9];
    logic [31:0] r_instr, r_pc, r_alu, r_rd, m_wd;
    logic [4:0]  m_a3;
    logic        m_we, r_v;
    ops = '{6'h00, 6'h0D, 6'h0F, 6'h23, 6'h20, 6'h24, 6'h21, 6'h25, 6'h2B};

    reset      = 1'b0;
    valid_M    = 1'b1;
    Instr_M    = 32'h0022_1821;
    PC_M       = 32'h0000_5000;
    ALUOut_M   = 32'h1;
    ReadData_M = 32'h0;
    exp_cnt    = 32'd0;
    prev_valid = 1'b0;
    #12;
    check_reset_outputs("reset_init");
    @(negedge clk);
    reset = 1'b1;

    issue(1'b1, 32'h0022_1821, 32'h0000_3004, 32'h0000_0005, 32'h0, 5'd3, 32'h5, 1'b1, "addu");
    issue(1'b1, 32'h8004_0000, 32'h0000_3008, 32'h0000_1001, 32'h1234_80FF, 5'd4, 32'hFFFF_FF80, 1'b1, "lb");
    issue(1'b1, 32'h9004_0000, 32'h0000_300C, 32'h0000_1001, 32'h1234_80FF, 5'd4, 32'h0000_0080, 1'b1, "lbu");
    issue(1'b1, 32'h8404_0000, 32'h0000_3010, 32'h0000_1003, 32'h1234_80FF, 5'd4, 32'h0000_1234, 1'b1, "lh_hi");
    issue(1'b1, 32'h8404_0000, 32'h0000_3014, 32'h0000_1000, 32'h1234_80FF, 5'd4, 32'hFFFF_80FF, 1'b1, "lh_lo");
    issue(1'b1, 32'h9404_0000, 32'h0000_3018, 32'h0000_1002, 32'h8765_4321, 5'd4, 32'h0000_8765, 1'b1, "lhu");
    issue(1'b1, 32'h8C05_0000, 32'h0000_301C, 32'h0000_1000, 32'hCAFE_BABE, 5'd5, 32'hCAFE_BABE, 1'b1, "lw");
    issue(1'b1, 32'h8004_0000, 32'h0000_3020, 32'h0000_1003, 32'h7F00_0000, 5'd4, 32'h0000_007F, 1'b1, "lb_b3");
    issue(1'b1, 32'h0C00_0C00, 32'h0000_3010, 32'h0000_0000, 32'h0, 5'd31, 32'h0000_3018, 1'b1, "jal");
    issue(1'b1, 32'h0C00_0C00, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0, 5'd31, 32'h0000_0004, 1'b1, "jal_wrap");
    issue(1'b1, 32'h3400_0007, 32'h0000_3024, 32'h0000_0007, 32'h0, 5'd0, 32'h0, 1'b0, "ori_r0");
    issue(1'b1, 32'h0022_1823, 32'h0000_3028, 32'hFFFF_FFFD, 32'h0, 5'd3, 32'hFFFF_FFFD, 1'b1, "subu");
    issue(1'b1, 32'h3C08_1234, 32'h0000_302C, 32'h1234_0000, 32'h0, 5'd8, 32'h1234_0000, 1'b1, "lui");
    issue(1'b0, 32'h0022_1821, 32'h0000_3030, 32'h0000_0009, 32'h0, 5'd0, 32'h0, 1'b0, "bubble");
    issue(1'b0, 32'h0022_1821, 32'h0000_3034, 32'h0000_0009, 32'h0, 5'd0, 32'h0, 1'b0, "bubble2");
    issue(1'b1, 32'hAC05_0000, 32'h0000_3038, 32'h0000_1000, 32'h0, 5'd0, 32'h0, 1'b0, "sw");
    issue(1'b1, 32'h03E0_0008, 32'h0000_303C, 32'h0000_0000, 32'h0, 5'd0, 32'h0, 1'b0, "jr");
    issue(1'b1, 32'h0022_1825, 32'h0000_3040, 32'h0000_0011, 32'h0, 5'd0, 32'h0, 1'b0, "or_unknown");

    for (int i = 0; i < 40; i++) begin
      r_instr = {ops[$urandom_range(0, 8)], 26'($urandom)};
      if (r_instr[31:26] == 6'h00) r_instr[5:0] = ($urandom_range(0, 1) == 0) ? 6'h21 : 6'h23;
      r_pc    = $urandom;
      r_alu   = $urandom;
      r_rd    = $urandom;
      r_v     = ($urandom_range(0, 3) != 0);
      model(r_v, r_instr, r_pc, r_alu, r_rd, m_a3, m_wd, m_we);
      issue(r_v, r_instr, r_pc, r_alu, r_rd, m_a3, m_wd, m_we, "rand");
    end

    issue(1'b1, 32'h0022_1821, 32'h0000_3100, 32'h1, 32'h0, 5'd3, 32'h1, 1'b1, "pre_rst0");
    issue(1'b1, 32'h0022_1821, 32'h0000_3104, 32'h2, 32'h0, 5'd3, 32'h2, 1'b1, "pre_rst1");
    issue(1'b1, 32'h0022_1821, 32'h0000_3108, 32'h3, 32'h0, 5'd3, 32'h3, 1'b1, "pre_rst2");
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    @(negedge clk);
    check_reset_outputs("reset_held");
    reset      = 1'b1;
    exp_cnt    = 32'd0;
    prev_valid = 1'b0;
    issue(1'b1, 32'h0C00_0C00, 32'h0000_3200, 32'h0, 32'h0, 5'd31, 32'h0000_3208, 1'b1, "post_rst0");
    issue(1'b1, 32'h3C09_0001, 32'h0000_3204, 32'h0001_0000, 32'h0, 5'd9, 32'h0001_0000, 1'b1, "post_rst1");
    check("sb_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
